// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: default bus widths and the arbiter FSM states.
package core_bus_arbiter_pkg;

    localparam int PTR_W  = 30;
    localparam int WORD_W = 32;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [WORD_W-1:0] word;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state;

    // Width of a channel index; a single channel still needs one bit to carry a value.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_arb_pick.sv
// Combinational winner selection: rotate the request vector to the round-robin origin,
// take the lowest set bit, then rotate the index back.
module core_arb_pick
    import core_bus_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int RR = 1,
    parameter int GW = sel_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_rr_ptr,
    output logic          o_valid,
    output logic [GW-1:0] o_grant
);

    localparam logic [GW:0] NL = (GW+1)'(N);

    logic [GW-1:0] w_base;
    logic [N-1:0]  w_rot;
    logic [GW:0]   w_idx;
    logic [GW-1:0] w_off;
    logic [GW:0]   w_sum;

    // Fixed priority is the same search with the origin pinned at channel 0.
    always_comb begin
        w_base  = (RR != 0) ? i_rr_ptr : '0;
        w_rot   = '0;
        w_idx   = '0;
        w_off   = '0;
        w_sum   = '0;
        o_valid = |i_req;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, GW'(k)} + {1'b0, w_base};
            if (w_idx >= NL) begin
                w_idx = w_idx - NL;
            end else begin
                w_idx = w_idx;
            end
            w_rot[k] = i_req[w_idx[GW-1:0]];
        end
        for (int k = N - 1; k >= 0; k--) begin
            w_off = w_rot[k] ? GW'(k) : w_off;
        end
        w_sum = {1'b0, w_off} + {1'b0, w_base};
        if (w_sum >= NL) begin
            o_grant = GW'(w_sum - NL);
        end else begin
            o_grant = w_sum[GW-1:0];
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel arbiter multiplexing core memory requesters onto the single start/ready bus,
// with per-channel pending latches so clients may pulse start while the bus is busy.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = $bits(ptr),
    parameter int DATA_W = $bits(word),
    parameter int RR     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N-1:0]          i_ch_start,
    input  logic [N-1:0]          i_ch_write,
    input  logic [N*ADDR_W-1:0]   i_ch_addr,
    input  logic [N*DATA_W-1:0]   i_ch_data_wr,
    output logic [N-1:0]          o_ch_ready,
    output logic [DATA_W-1:0]     o_ch_data_rd,
    output logic                  o_bus_start,
    output logic                  o_bus_write,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_data_wr,
    input  logic                  i_bus_ready,
    input  logic [DATA_W-1:0]     i_bus_data_rd
);

    localparam int GW = sel_w(N);

    arb_state            r_state;
    logic [N-1:0]        r_pend;
    logic [N-1:0]        r_lat_write;
    logic [ADDR_W-1:0]   r_lat_addr [N];
    logic [DATA_W-1:0]   r_lat_data [N];
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_rr_ptr;
    logic                r_bus_start;
    logic                r_bus_write;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_data_wr;

    logic [N-1:0]        w_start_ok;
    logic [N-1:0]        w_req;
    logic                w_arb_en;
    logic                w_valid;
    logic [GW-1:0]       w_pick;
    logic                w_issue;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [GW-1:0]       w_next_ptr;

    // A repeat pulse from a channel already queued or still owning the bus is dropped;
    // the owner may re-request in the very cycle its transfer completes.
    always_comb begin
        w_start_ok = '0;
        for (int i = 0; i < N; i++) begin
            if ((r_state == ARB_WAIT) && (r_grant == GW'(i)) && !i_bus_ready) begin
                w_start_ok[i] = 1'b0;
            end else begin
                w_start_ok[i] = i_ch_start[i] & ~r_pend[i];
            end
        end
        w_req = r_pend | w_start_ok;
    end

    // Arbitration happens from idle, or on the completing edge of the current transfer.
    always_comb begin
        case (r_state)
            ARB_IDLE: w_arb_en = 1'b1;
            ARB_WAIT: w_arb_en = i_bus_ready;
            default:  w_arb_en = 1'b0;
        endcase
        w_issue = w_arb_en & w_valid;
    end

    core_arb_pick #(
        .N  (N),
        .RR (RR),
        .GW (GW)
    ) u_pick (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_valid),
        .o_grant  (w_pick)
    );

    // Winner's request comes from its latch if queued, otherwise straight from the pins.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_write = (w_pick == GW'(i)) ? (r_pend[i] ? r_lat_write[i] : i_ch_write[i]) : w_sel_write;
            w_sel_addr  = (w_pick == GW'(i)) ? (r_pend[i] ? r_lat_addr[i] : i_ch_addr[i*ADDR_W +: ADDR_W]) : w_sel_addr;
            w_sel_data  = (w_pick == GW'(i)) ? (r_pend[i] ? r_lat_data[i] : i_ch_data_wr[i*DATA_W +: DATA_W]) : w_sel_data;
        end
        w_next_ptr = (w_pick == GW'(N - 1)) ? '0 : w_pick + GW'(1);
    end

    // Completion is routed to the owning channel with no added latency.
    always_comb begin
        o_ch_ready = '0;
        for (int i = 0; i < N; i++) begin
            o_ch_ready[i] = (r_state == ARB_WAIT) && i_bus_ready && (r_grant == GW'(i));
        end
    end

    // FSM, pending latches, round-robin pointer and the registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ARB_IDLE;
            r_pend        <= '0;
            r_lat_write   <= '0;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_bus_start   <= 1'b0;
            r_bus_write   <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_data_wr <= '0;
            for (int i = 0; i < N; i++) begin
                r_lat_addr[i] <= '0;
                r_lat_data[i] <= '0;
            end
        end else begin
            r_bus_start <= 1'b0;
            for (int i = 0; i < N; i++) begin
                if (w_issue && (w_pick == GW'(i))) begin
                    r_pend[i] <= 1'b0;
                end else if (w_start_ok[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_lat_write[i] <= i_ch_write[i];
                    r_lat_addr[i]  <= i_ch_addr[i*ADDR_W +: ADDR_W];
                    r_lat_data[i]  <= i_ch_data_wr[i*DATA_W +: DATA_W];
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
            if (w_issue) begin
                r_bus_start   <= 1'b1;
                r_bus_write   <= w_sel_write;
                r_bus_addr    <= w_sel_addr;
                r_bus_data_wr <= w_sel_data;
                r_grant       <= w_pick;
                r_rr_ptr      <= w_next_ptr;
            end else begin
                r_grant <= r_grant;
            end
            case (r_state)
                ARB_IDLE: r_state <= w_issue ? ARB_WAIT : ARB_IDLE;
                ARB_WAIT: r_state <= (i_bus_ready && !w_issue) ? ARB_IDLE : ARB_WAIT;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign o_bus_start   = r_bus_start;
    assign o_bus_write   = r_bus_write;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_data_wr = r_bus_data_wr;
    assign o_ch_data_rd  = i_bus_data_rd;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: a fixed-priority 4-channel instance driven from a vector table
// and hand sequences, plus a 3-channel round-robin instance for fairness.
module tb_core_bus_arbiter;

    localparam int FN = 4;
    localparam int RN = 3;
    localparam int AW = 30;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [FN-1:0]    fp_start, fp_wr, fp_ready_ch;
    logic [FN*AW-1:0] fp_addr;
    logic [FN*DW-1:0] fp_wdata;
    logic [DW-1:0]    fp_rd, fp_bwdata, fp_brdata;
    logic [AW-1:0]    fp_baddr;
    logic             fp_bstart, fp_bwrite, fp_bready;

    logic [RN-1:0]    rr_start, rr_ready_ch;
    logic [RN*AW-1:0] rr_addr;
    logic [RN*DW-1:0] rr_wdata;
    logic [DW-1:0]    rr_rd, rr_bwdata, rr_brdata;
    logic [AW-1:0]    rr_baddr;
    logic             rr_bstart, rr_bwrite, rr_bready;

    core_bus_arbiter #(.N(FN), .ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_ch_start(fp_start), .i_ch_write(fp_wr),
        .i_ch_addr(fp_addr), .i_ch_data_wr(fp_wdata), .o_ch_ready(fp_ready_ch),
        .o_ch_data_rd(fp_rd), .o_bus_start(fp_bstart), .o_bus_write(fp_bwrite),
        .o_bus_addr(fp_baddr), .o_bus_data_wr(fp_bwdata), .i_bus_ready(fp_bready),
        .i_bus_data_rd(fp_brdata));

    core_bus_arbiter #(.N(RN), .ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_ch_start(rr_start), .i_ch_write(3'b000),
        .i_ch_addr(rr_addr), .i_ch_data_wr(rr_wdata), .o_ch_ready(rr_ready_ch),
        .o_ch_data_rd(rr_rd), .o_bus_start(rr_bstart), .o_bus_write(rr_bwrite),
        .o_bus_addr(rr_baddr), .o_bus_data_wr(rr_bwdata), .i_bus_ready(rr_bready),
        .i_bus_data_rd(rr_brdata));

    typedef struct {
        int          ch;
        logic        wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic        first;
        int          start_cyc;
    } exp_t;

    typedef struct {
        logic [3:0]    start;
        logic [3:0]    wr;
        logic [AW-1:0] base;
        logic [7:0]    order;
        int            cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   rd_idx = 0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fp_cur = 0, fp_cnt = 0, fp_nresp = 0, fp_last_ready = 0;
    logic fp_infl = 1'b0, fp_stray = 1'b0;
    int   rr_cnt = 0, rr_done = 0, rr_reqs = 0;
    localparam int RR_TARGET = 6;

    function automatic logic [DW-1:0] dval(input logic [AW-1:0] a);
        return {2'b01, a} ^ 32'h0F0F0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic first);
        exp_t e;
        e.ch = ch; e.wr = wr; e.addr = a; e.data = d; e.first = first; e.start_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        int   ch;
        if (fp_bstart) begin
            if (rd_idx < sb.size()) begin
                e = sb[rd_idx];
                rd_idx++;
                chk("issue_addr", fp_baddr, e.addr);
                chk("issue_write", fp_bwrite, e.wr);
                chk("issue_data", fp_bwdata, e.data);
                if (e.first) chk("issue_latency", cyc, e.start_cyc + 1);
                else         chk("back_to_back", cyc, fp_last_ready + 1);
                fp_cur  = e.ch;
                fp_infl = 1'b1;
            end else begin
                chk("unexpected_issue", fp_bstart, 1'b0);
            end
        end
        if (fp_bready) begin
            if (fp_infl) begin
                chk("ch_ready", fp_ready_ch, 4'b0001 << fp_cur);
                chk("ch_data_rd", fp_rd, 32'hDEADBEEF ^ (fp_nresp - 1));
                fp_infl = 1'b0;
                fp_last_ready = cyc;
            end else begin
                chk("stray_ready", fp_ready_ch, 4'b0000);
            end
        end else begin
            chk("ready_quiet", fp_ready_ch, 4'b0000);
        end
        if (rr_bready) begin
            chk("rr_grant", rr_ready_ch, (rr_done % 2 == 0) ? 3'b001 : 3'b100);
            rr_done++;
            ch = rr_ready_ch[2] ? 2 : (rr_ready_ch[1] ? 1 : 0);
            if (rr_reqs < RR_TARGET) begin
                rr_start[ch] = 1'b1;
                rr_reqs++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        rr_start = '0;
        if (rst) begin
            fp_cnt = 0; fp_bready = 1'b0;
        end else if (fp_stray) begin
            fp_bready = 1'b1; fp_brdata = 32'hBAD0BAD0; fp_stray = 1'b0;
        end else if (fp_bstart) begin
            fp_cnt = 3; fp_bready = 1'b0;
        end else if (fp_cnt > 0) begin
            fp_cnt--;
            fp_bready = (fp_cnt == 0);
            if (fp_bready) begin
                fp_brdata = 32'hDEADBEEF ^ fp_nresp;
                fp_nresp++;
            end
        end else begin
            fp_bready = 1'b0;
        end
        if (rst) begin
            rr_cnt = 0; rr_bready = 1'b0;
        end else if (rr_bstart) begin
            rr_cnt = 2; rr_bready = 1'b0;
        end else if (rr_cnt > 0) begin
            rr_cnt--;
            rr_bready = (rr_cnt == 0);
        end else begin
            rr_bready = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!((rd_idx == sb.size()) && !fp_infl) && (n < 200)) begin
            tick();
            n++;
        end
        chk("drain_fp", (rd_idx == sb.size()) && !fp_infl, 1'b1);
        repeat (3) tick();
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        fp_wr[ch] = wr;
        fp_addr[ch*AW +: AW] = a;
        fp_wdata[ch*DW +: DW] = d;
    endtask

    initial begin
        int n;
        int ch;
        logic [AW-1:0] a;
        vecs[0] = '{4'b0001, 4'b0000, 30'h100, {2'd0, 2'd0, 2'd0, 2'd0}, 1};
        vecs[1] = '{4'b1111, 4'b0101, 30'h200, {2'd3, 2'd2, 2'd1, 2'd0}, 4};
        vecs[2] = '{4'b1010, 4'b1000, 30'h300, {2'd0, 2'd0, 2'd3, 2'd1}, 2};
        vecs[3] = '{4'b0110, 4'b0010, 30'h400, {2'd0, 2'd0, 2'd2, 2'd1}, 2};
        vecs[4] = '{4'b1000, 4'b1000, 30'h500, {2'd0, 2'd0, 2'd0, 2'd3}, 1};
        vecs[5] = '{4'b1100, 4'b0000, 30'h600, {2'd0, 2'd0, 2'd3, 2'd2}, 2};

        rst = 1'b1;
        fp_start = '0; fp_wr = '0; fp_addr = '0; fp_wdata = '0;
        fp_bready = 1'b0; fp_brdata = '0;
        rr_start = '0; rr_bready = 1'b0; rr_brdata = 32'h00C0FFEE;
        rr_addr = {30'h3000, 30'h2000, 30'h1000};
        rr_wdata = '0;
        tick();
        tick();
        chk("rst_bus_start", fp_bstart, 1'b0);
        chk("rst_bus_write", fp_bwrite, 1'b0);
        chk("rst_bus_addr", fp_baddr, 30'h0);
        chk("rst_bus_data_wr", fp_bwdata, 32'h0);
        chk("rst_ch_ready", fp_ready_ch, 4'b0000);
        chk("rst_rr_bus_start", rr_bstart, 1'b0);
        rst = 1'b0;
        tick();

        // Round-robin fairness: both channels re-request in the cycle of their completion.
        rr_start = 3'b101;
        rr_reqs = 2;
        n = 0;
        while ((rr_done < RR_TARGET) && (n < 300)) begin
            tick();
            n++;
        end
        chk("rr_completions", rr_done, RR_TARGET);
        repeat (4) tick();

        // Table-driven fixed-priority batches.
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < FN; c++) begin
                a = vecs[v].base + AW'(c * 16);
                set_ch(c, vecs[v].wr[c], a, dval(a));
            end
            for (int k = 0; k < vecs[v].cnt; k++) begin
                ch = int'(vecs[v].order[2*k +: 2]);
                a = vecs[v].base + AW'(ch * 16);
                push(ch, vecs[v].wr[ch], a, dval(a), k == 0);
            end
            fp_start = vecs[v].start;
            tick();
            fp_start = '0;
            fp_addr = '1; fp_wdata = '1; fp_wr = ~fp_wr;
            drain();
        end

        // Write from channel 1 latched while channel 0 owns the bus; pins change afterwards.
        set_ch(0, 1'b0, 30'h700, dval(30'h700));
        push(0, 1'b0, 30'h700, dval(30'h700), 1'b1);
        fp_start = 4'b0001;
        tick();
        set_ch(1, 1'b1, 30'h40, 32'h12345678);
        push(1, 1'b1, 30'h40, 32'h12345678, 1'b0);
        fp_start = 4'b0010;
        tick();
        fp_start = '0;
        set_ch(1, 1'b0, 30'h3FFFFFFF, 32'h0);
        drain();

        // Repeat pulse while already pending must not overwrite the latch or issue twice.
        set_ch(2, 1'b0, 30'hA00, dval(30'hA00));
        push(2, 1'b0, 30'hA00, dval(30'hA00), 1'b1);
        fp_start = 4'b0100;
        tick();
        set_ch(0, 1'b0, 30'h800, dval(30'h800));
        push(0, 1'b0, 30'h800, dval(30'h800), 1'b0);
        fp_start = 4'b0001;
        tick();
        set_ch(0, 1'b1, 30'h880, dval(30'h880));
        fp_start = 4'b0001;
        tick();
        fp_start = '0;
        drain();
        repeat (8) tick();

        // Reset during a transfer with channel 1 queued, then a stray bus_ready.
        set_ch(0, 1'b1, 30'hB00, dval(30'hB00));
        push(0, 1'b1, 30'hB00, dval(30'hB00), 1'b1);
        fp_start = 4'b0001;
        tick();
        set_ch(1, 1'b1, 30'hC00, dval(30'hC00));
        fp_start = 4'b0010;
        tick();
        fp_start = '0;
        tick();
        rst = 1'b1;
        tick();
        fp_infl = 1'b0;
        rst = 1'b0;
        fp_stray = 1'b1;
        tick();
        chk("post_rst_ready", fp_ready_ch, 4'b0000);
        chk("post_rst_start", fp_bstart, 1'b0);
        chk("post_rst_write", fp_bwrite, 1'b0);
        chk("post_rst_addr", fp_baddr, 30'h0);
        chk("post_rst_data", fp_bwdata, 32'h0);
        repeat (10) tick();
        chk("post_rst_no_issue", fp_bstart, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
